// File: rtl/pwm_fade_multi_pkg.sv
// rtl/pwm_fade_multi_pkg.sv - shared types and helpers for the multi-channel PWM fader
//
// Purpose: mode and direction encodings plus the hold-counter width helper,
//          imported by pwm_fade_ch and pwm_fade_multi.
// Ports:   none (package).

package pwm_fade_multi_pkg;

  // Per-channel 2-bit mode, as seen on the top-level mode bus.
  typedef enum logic [1:0] {
    MODE_FADE    = 2'b00,
    MODE_HOLD    = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_OFF     = 2'b11
  } mode_e;

  // Fade direction; only BREATHE ever ramps up.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Hold counter must represent HOLD_CYCLES; keep at least one bit so a
  // zero-hold build still has a legal (constant-zero) register.
  function automatic int hold_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pwm_fade_ch.sv
// rtl/pwm_fade_ch.sv - one fade engine with level mapping and drive/busy registers
//
// Purpose: per-channel brightness envelope (fade, hold-then-fade, breathe, off)
//          compared against the shared PWM counter.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   trigger  in   (re)start strobe for this channel
//   mode     in   2-bit mode (FADE/HOLD/BREATHE/OFF)
//   pwm_cnt  in   shared free-running PWM counter
//   drive    out  registered PWM output
//   busy     out  registered "not dark-and-idle" flag

import pwm_fade_multi_pkg::*;

module pwm_fade_ch #(
  parameter int LEVEL_BITS  = 8,
  parameter int FADE_BITS   = 27,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trigger,
  input  logic [1:0]            mode,
  input  logic [LEVEL_BITS-1:0] pwm_cnt,
  output logic                  drive,
  output logic                  busy
);

  localparam int HW = hold_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);

  mode_e                 mode_q;
  logic [FADE_BITS-1:0]  fade_cnt, fade_nxt;
  logic [HW-1:0]         hold_cnt, hold_nxt;
  dir_e                  dir, dir_nxt;
  logic [LEVEL_BITS-1:0] top;
  logic [LEVEL_BITS:0]   level;

  assign mode_q = mode_e'(mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fade_cnt <= '0;
      hold_cnt <= '0;
      dir      <= DIR_DOWN;
      drive    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      fade_cnt <= fade_nxt;
      hold_cnt <= hold_nxt;
      dir      <= dir_nxt;
      drive    <= ({1'b0, pwm_cnt} < level);
      busy     <= (fade_cnt != '0) || (hold_cnt != '0) || (mode_q == MODE_BREATHE);
    end
  end

  // Envelope next-state. FADE/HOLD force dir down every step, so a later
  // switch into BREATHE starts downward unless already at zero, in which
  // case the bottom turnaround flips it up.
  always_comb begin
    fade_nxt = fade_cnt;
    hold_nxt = hold_cnt;
    dir_nxt  = dir;
    if (mode_q == MODE_OFF) begin
      fade_nxt = '0;
      hold_nxt = '0;
      dir_nxt  = DIR_DOWN;
    end else if (trigger) begin
      fade_nxt = '1;
      dir_nxt  = DIR_DOWN;
      hold_nxt = (mode_q == MODE_HOLD) ? HOLD_INIT : '0;
    end else if (hold_cnt != '0) begin
      hold_nxt = hold_cnt - HW'(1);
    end else if (mode_q != MODE_BREATHE) begin
      dir_nxt = DIR_DOWN;
      if (fade_cnt != '0) begin
        fade_nxt = fade_cnt - FADE_BITS'(1);
      end
    end else if (dir == DIR_DOWN) begin
      // Turnarounds spend one clock at the extreme, giving a 2*2**FADE_BITS period.
      if (fade_cnt == '0) begin
        dir_nxt = DIR_UP;
      end else begin
        fade_nxt = fade_cnt - FADE_BITS'(1);
      end
    end else begin
      if (fade_cnt == '1) begin
        dir_nxt = DIR_DOWN;
      end else begin
        fade_nxt = fade_cnt + FADE_BITS'(1);
      end
    end
  end

  // Top bits map to a level one wider than the PWM counter: 0 stays 0 (dark),
  // otherwise top+1, so all-ones reaches 2**LEVEL_BITS (always on).
  assign top   = fade_cnt[FADE_BITS-1 -: LEVEL_BITS];
  assign level = (top == '0) ? '0 : ({1'b0, top} + (LEVEL_BITS+1)'(1));

endmodule

// File: rtl/pwm_fade_multi.sv
// rtl/pwm_fade_multi.sv - multi-channel PWM LED fader top level
//
// Purpose: shared free-running PWM counter feeding NUM_CH independent fade
//          channels for board status LEDs.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   trigger  in   [NUM_CH]     per-channel (re)start strobe
//   mode     in   [2*NUM_CH]   channel i mode at mode[2i+1:2i]
//   drive    out  [NUM_CH]     registered PWM outputs
//   busy     out  [NUM_CH]     registered per-channel activity flags

import pwm_fade_multi_pkg::*;

module pwm_fade_multi #(
  parameter int NUM_CH      = 4,
  parameter int LEVEL_BITS  = 8,
  parameter int FADE_BITS   = 27,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     trigger,
  input  logic [2*NUM_CH-1:0]   mode,
  output logic [NUM_CH-1:0]     drive,
  output logic [NUM_CH-1:0]     busy
);

  logic [LEVEL_BITS-1:0] pwm_cnt;

  // Wraps naturally at 2**LEVEL_BITS-1 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + LEVEL_BITS'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_fade_ch #(
      .LEVEL_BITS  (LEVEL_BITS),
      .FADE_BITS   (FADE_BITS),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .trigger (trigger[i]),
      .mode    (mode[2*i +: 2]),
      .pwm_cnt (pwm_cnt),
      .drive   (drive[i]),
      .busy    (busy[i])
    );
  end

endmodule

// File: tb/tb_pwm_fade_multi.sv
// tb/tb_pwm_fade_multi.sv - self-checking bench for pwm_fade_multi

module tb_pwm_fade_multi;

  localparam int NC   = 2;
  localparam int LB   = 4;
  localparam int FB   = 8;
  localparam int HC   = 5;
  localparam int FMAX = (1 << FB) - 1;
  localparam int PMOD = 1 << LB;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC-1:0]   trigger;
  logic [2*NC-1:0] mode;
  logic [NC-1:0]   drive;
  logic [NC-1:0]   busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers, one entry per channel.
  int mf[NC];
  int mh[NC];
  int mup[NC];
  int mpwm;
  logic [NC-1:0] mdrive;
  logic [NC-1:0] mbusy;

  pwm_fade_multi #(
    .NUM_CH      (NC),
    .LEVEL_BITS  (LB),
    .FADE_BITS   (FB),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trigger (trigger),
    .mode    (mode),
    .drive   (drive),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lvl(input int f);
    int t;
    t = f / (1 << (FB - LB));
    return (t == 0) ? 0 : t + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      mf[i] = 0; mh[i] = 0; mup[i] = 0;
    end
    mpwm = 0;
    mdrive = '0;
    mbusy = '0;
  endtask

  // Advances the model across one rising edge using the current inputs.
  task automatic model_edge();
    int m;
    for (int i = 0; i < NC; i++) begin
      m = int'(mode[2*i +: 2]);
      mdrive[i] = (mpwm < lvl(mf[i]));
      mbusy[i]  = (mf[i] != 0) || (mh[i] != 0) || (m == 2);
      if (m == 3) begin
        mf[i] = 0; mh[i] = 0; mup[i] = 0;
      end else if (trigger[i]) begin
        mf[i] = FMAX; mup[i] = 0; mh[i] = (m == 1) ? HC : 0;
      end else if (mh[i] > 0) begin
        mh[i]--;
      end else if (m != 2) begin
        mup[i] = 0;
        if (mf[i] > 0) mf[i]--;
      end else if (mup[i] == 0) begin
        if (mf[i] == 0) mup[i] = 1; else mf[i]--;
      end else begin
        if (mf[i] == FMAX) mup[i] = 0; else mf[i]++;
      end
    end
    mpwm = (mpwm + 1) % PMOD;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk(tag, {28'd0, drive, busy}, {28'd0, mdrive, mbusy});
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  task automatic pulse(input int ch, input string tag);
    trigger[ch] = 1'b1;
    tick(tag);
    trigger[ch] = 1'b0;
  endtask

  task automatic wait_fade(input int ch, input int val, input string tag);
    int n;
    n = 0;
    while (mf[ch] != val && n < 600) begin
      tick(tag);
      n++;
    end
    if (mf[ch] != val) chk({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  initial begin
    int cnt;
    rst_n   = 1'b0;
    trigger = '0;
    mode    = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {28'd0, drive, busy}, 32'd0);
    rst_n = 1'b1;

    // Reset asserted mid-fade clears outputs without waiting for a clock.
    set_mode(0, 2'b00);
    pulse(0, "t1_trig");
    repeat (40) tick("t1_fade");
    #2 rst_n = 1'b0;
    #1 chk("t1_async_reset", {28'd0, drive, busy}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick("t1_idle");

    // One-shot fade: full-on run, then busy for exactly 255 samples.
    pulse(0, "t2_trig");
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      tick("t2_top");
      cnt += int'(drive[0]);
    end
    chk("t2_full_on", 32'(cnt), 32'd16);
    cnt = 16;
    for (int k = 0; k < 280; k++) begin
      tick("t2_fade");
      cnt += int'(busy[0]);
    end
    chk("t2_busy_len", 32'(cnt), 32'd255);

    // Hold-then-fade: five extra clocks at max, then retrigger mid-fade.
    set_mode(1, 2'b01);
    pulse(1, "t3_trig");
    cnt = 0;
    for (int k = 0; k < 280; k++) begin
      tick("t3_hold");
      cnt += int'(busy[1]);
    end
    chk("t3_busy_len", 32'(cnt), 32'd260);
    pulse(1, "t3_trig2");
    wait_fade(1, 8'h80, "t3_wait");
    pulse(1, "t3_retrig");
    repeat (30) tick("t3_rehold");

    // Breathe from idle: busy never drops across more than a full period.
    set_mode(0, 2'b10);
    cnt = 0;
    for (int k = 0; k < 600; k++) begin
      tick("t4_breathe");
      cnt += int'(!busy[0]);
    end
    chk("t4_busy_gaps", 32'(cnt), 32'd0);

    // OFF with a simultaneous trigger wins and goes dark.
    set_mode(0, 2'b00);
    pulse(0, "t5_trig");
    wait_fade(0, 8'h90, "t5_wait");
    set_mode(0, 2'b11);
    trigger[0] = 1'b1;
    tick("t5_off_trig");
    trigger[0] = 1'b0;
    tick("t5_off");
    chk("t5_dark", {30'd0, drive[0], busy[0]}, 32'd0);
    repeat (10) tick("t5_idle");

    // Independence: both channels triggered together in different modes.
    set_mode(0, 2'b00);
    set_mode(1, 2'b10);
    trigger = '1;
    tick("t6_trig");
    trigger = '0;
    repeat (300) tick("t6_run");

    // Random triggers and mode changes.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NC; i++) begin
        trigger[i] = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 149) == 0) set_mode(i, 2'($urandom_range(0, 3)));
      end
      tick("rand");
    end
    trigger = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
